// File: rtl/comparator_seq_pkg.sv
// Shared types and result decode for the digit-serial magnitude comparator.
// Mode encoding matches the 2-bit mode port directly.
package comparator_seq_pkg;

  typedef enum logic [1:0] {
    CMP_ULT = 2'b00,
    CMP_SLT = 2'b01,
    CMP_EQ  = 2'b10,
    CMP_ULE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // lt already carries the signedness, so ULT and SLT decode identically here.
  function automatic logic mode_result(input mode_t m, input logic lt, input logic eq);
    logic r;
    case (m)
      CMP_ULT, CMP_SLT: r = lt;
      CMP_EQ:           r = eq;
      default:          r = lt | eq;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/comparator_seq_digit_cmp.sv
// Combinational unsigned compare of one DIGIT-bit digit pair.
// Zero latency, no handshake.
module digit_cmp #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             lt,
  output logic             eq
);

  assign lt = (a < b);
  assign eq = (a == b);

endmodule

// File: rtl/comparator_seq.sv
// Digit-serial comparator: ULT/SLT/EQ/ULE, MSB digit first; NDIG+1 cycles accept-to-valid (constant time),
// or data-dependent with COMPARATOR_SEQ_EARLY_EXIT_EN; result held in DONE until out_ready, in_ready only in IDLE.
module comparator_seq
  import comparator_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             res,
  output logic             lt,
  output logic             eq
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0]    IDX_TOP  = IW'(NDIG - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, a_nxt;
  logic [WIDTH-1:0] b_r, b_nxt;
  mode_t            mode_r, mode_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic             decided, decided_nxt;
  logic             lt_r, lt_r_nxt;
  logic             res_nxt, lt_nxt, eq_nxt;
  logic             last;

  logic [DIGIT-1:0] dig_a, dig_b;
  logic             dig_lt, dig_eq;

  always_comb begin
    dig_a = '0;
    dig_b = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        dig_a = a_r[i*DIGIT +: DIGIT];
        dig_b = b_r[i*DIGIT +: DIGIT];
      end
    end
  end

  digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
    .a  (dig_a),
    .b  (dig_b),
    .lt (dig_lt),
    .eq (dig_eq)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_comb begin
    state_nxt   = state;
    a_nxt       = a_r;
    b_nxt       = b_r;
    mode_nxt    = mode_r;
    idx_nxt     = idx;
    decided_nxt = decided;
    lt_r_nxt    = lt_r;
    res_nxt     = res;
    lt_nxt      = lt;
    eq_nxt      = eq;
    last        = 1'b0;

    case (state)
      IDLE: begin
        if (in_valid) begin
          // Flipping both sign bits at capture turns the signed compare into an
          // unsigned one; equality is unaffected.
          if (mode_t'(mode) == CMP_SLT) begin
            a_nxt = a ^ MSB_MASK;
            b_nxt = b ^ MSB_MASK;
          end else begin
            a_nxt = a;
            b_nxt = b;
          end
          mode_nxt    = mode_t'(mode);
          idx_nxt     = IDX_TOP;
          decided_nxt = 1'b0;
          lt_r_nxt    = 1'b0;
          state_nxt   = RUN;
        end
      end

      RUN: begin
        if (!decided && !dig_eq) begin
          decided_nxt = 1'b1;
          lt_r_nxt    = dig_lt;
        end
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
        last = (idx == '0) || decided_nxt;
`else
        last = (idx == '0);
`endif
        if (last) begin
          state_nxt = DONE;
          lt_nxt    = lt_r_nxt;
          eq_nxt    = ~decided_nxt;
          res_nxt   = mode_result(mode_r, lt_r_nxt, ~decided_nxt);
        end else begin
          idx_nxt = idx - 1'b1;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      mode_r  <= CMP_ULT;
      idx     <= '0;
      decided <= 1'b0;
      lt_r    <= 1'b0;
      res     <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_r     <= a_nxt;
      b_r     <= b_nxt;
      mode_r  <= mode_nxt;
      idx     <= idx_nxt;
      decided <= decided_nxt;
      lt_r    <= lt_r_nxt;
      res     <= res_nxt;
      lt      <= lt_nxt;
      eq      <= eq_nxt;
    end
  end

endmodule
